// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage constants, state encoding and PC helper
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^32 with no carry out.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-stage bus: imem port, decode controls and IF/ID outputs
interface fetch_stage_if;
    logic        stall;
    logic        pc_sel;
    logic [31:0] npc;
    logic [31:0] imem_instr;
    logic        imem_ready;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        valid_d;

    modport master (
        input  stall, pc_sel, npc, imem_instr, imem_ready,
        output pc_f, instr_d, pc4_d, valid_d
    );

    modport slave (
        output stall, pc_sel, npc, imem_instr, imem_ready,
        input  pc_f, instr_d, pc4_d, valid_d
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register (instr, pc+4, valid) with hold/load/bubble
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // hold wins over load, load wins over bubble; none asserted keeps contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr <= NOP;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                instr <= instr_in;
                pc4   <= pc4_in;
                valid <= 1'b1;
            end else if (bubble) begin
                instr <= NOP;
                pc4   <= 32'h0;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage; DELAY_SLOT_EN selects branch-delay-slot semantics
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc4_f;
    logic        ifid_load;
    logic        ifid_bubble;

    assign pc4_f    = pc_plus4(pc_q);
    assign bus.pc_f = pc_q;

`ifdef DELAY_SLOT_EN
    fetch_state_t state_q;
    fetch_state_t state_next;
    logic [31:0]  target_q;
    logic [31:0]  target_next;

    always_comb begin
        pc_next     = pc_q;
        state_next  = state_q;
        target_next = target_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (!bus.stall) begin
            if (state_q == PEND) begin
                // Delay slot still owed; decode sees only bubbles so pc_sel is ignored here.
                if (bus.imem_ready) begin
                    ifid_load  = 1'b1;
                    pc_next    = target_q;
                    state_next = RUN;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end else if (bus.pc_sel) begin
                if (bus.imem_ready) begin
                    ifid_load = 1'b1;
                    pc_next   = bus.npc;
                end else begin
                    ifid_bubble = 1'b1;
                    target_next = bus.npc;
                    state_next  = PEND;
                end
            end else if (bus.imem_ready) begin
                ifid_load = 1'b1;
                pc_next   = pc4_f;
            end else begin
                ifid_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            state_q  <= RUN;
            target_q <= 32'h0;
        end else begin
            pc_q     <= pc_next;
            state_q  <= state_next;
            target_q <= target_next;
        end
    end
`else
    always_comb begin
        pc_next     = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (!bus.stall) begin
            if (bus.pc_sel) begin
                // Flush: the instruction behind the branch is discarded.
                pc_next     = bus.npc;
                ifid_bubble = 1'b1;
            end else if (bus.imem_ready) begin
                ifid_load = 1'b1;
                pc_next   = pc4_f;
            end else begin
                ifid_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end
`endif

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .hold     (bus.stall),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .instr_in (bus.imem_instr),
        .pc4_in   (pc4_f),
        .instr    (bus.instr_d),
        .pc4      (bus.pc4_d),
        .valid    (bus.valid_d)
    );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset).
REQ-004 stall  input  1  hazard-unit stall: hold PC, IF/ID and pending state.
REQ-005 pc_sel  input  1  from decode control: 0 = PC+4, 1 = redirect to npc.
REQ-006 npc  input  32  redirect target from decode (branch/j/jal/jr).
REQ-007 imem_instr  input  32  instruction memory read data for address pc_f.
REQ-008 imem_ready  input  1  imem_instr valid this cycle.
REQ-009 pc_f  output  32  fetch address to instruction memory.
REQ-010 instr_d  output  32  IF/ID instruction to decode.
REQ-011 pc4_d  output  32  IF/ID PC+4 to decode.
REQ-012 valid_d  output  1  IF/ID slot holds a real instruction.

Function
REQ-013 A fetch SHALL complete in any cycle with imem_ready=1 and stall=0; the completed instruction is {imem_instr, pc_f+4}.
REQ-014 Normal advance (stall=0, pc_sel=0, ready=1): next cycle instr_d=imem_instr, pc4_d=pc_f+4, valid_d=1, pc_f=pc_f+4.
REQ-015 Memory wait (stall=0, ready=0, no redirect): pc_f SHALL hold; IF/ID SHALL take a bubble (instr_d=32'h0, valid_d=0, pc4_d=0).
REQ-016 stall=1 SHALL have priority over all events: pc_f, IF/ID, pending flag and saved target hold; pc_sel ignored.
REQ-017 A redirect SHALL be accepted only when stall=0 and pc_sel=1, regardless of imem_ready.
REQ-018 PC arithmetic SHALL be 32-bit modulo; pc_f+4 wraps 32'hFFFF_FFFC to 32'h0 with no flag.
REQ-019 States: RUN (no pending redirect) and PEND (redirect target saved, delay slot not yet fetched); PEND exists only with DELAY_SLOT_EN.
REQ-020 Without DELAY_SLOT_EN: on accepted redirect, pc_f<=npc and IF/ID takes a bubble, independent of imem_ready.
REQ-021 With DELAY_SLOT_EN, redirect with ready=1: delay-slot instruction loads into IF/ID (valid_d=1), pc_f<=npc, state stays RUN.
REQ-022 With DELAY_SLOT_EN, redirect with ready=0: target<=npc, state RUN->PEND, pc_f holds, IF/ID bubble.
REQ-023 In PEND with ready=1 and stall=0: slot loads into IF/ID, pc_f<=target, PEND->RUN; with ready=0, stay in PEND and IF/ID takes a bubble.
REQ-024 pc_sel SHALL be ignored in PEND (IF/ID holds a bubble, so decode cannot redirect).

Reset
REQ-025 Asserting reset SHALL immediately force pc_f=32'h0000_3000, instr_d=0, pc4_d=0, valid_d=0, state=RUN, target=0, including mid-wait or mid-PEND.
REQ-026 The first fetch SHALL occur at 32'h0000_3000 in the first clock edge after reset deasserts.

Configuration
REQ-027 Macro DELAY_SLOT_EN defined: MIPS branch-delay-slot semantics per REQ-021..024, with PEND state and target register present.
REQ-028 Macro DELAY_SLOT_EN undefined: flush-on-redirect per REQ-020, with no PEND state and no target register.

Structure
REQ-029 The shared definitions header SHALL hold RESET_PC (32'h0000_3000), NOP (32'h0) and the RUN/PEND state encodings.
REQ-030 The IF/ID register SHALL be the sub-module if_id_reg, with load/hold/bubble controls, async active-low reset and 32+32+1 bits.
REQ-031 PC register, state machine and next-PC selection SHALL reside in fetch_stage.

Verification
REQ-032 Reset release with ready=1 for 3 cycles SHALL give pc_f = 3000, 3004, 3008, 300C and pc4_d = 3004, 3008 with valid_d=1.
REQ-033 With stall=1 for 2 cycles at pc_f=3008 and pc_sel=1, pc_f, instr_d and valid_d SHALL hold, and no redirect SHALL occur until stall falls.
REQ-034 Without the macro, pc_sel=1, npc=3100, ready=1 SHALL give pc_f=3100 and valid_d=0 next cycle, then instr@3100 in D.
REQ-035 With the macro, pc_sel=1, npc=3100, ready=0 SHALL enter PEND with pc_f held; two cycles later ready=1 SHALL put the slot in D (valid_d=1) and set pc_f=3100.
REQ-036 Reset asserted mid-PEND SHALL immediately give pc_f=3000, valid_d=0 and state RUN.
REQ-037 pc_f=FFFF_FFFC with ready=1 SHALL give pc_f=0000_0000 and pc4_d=0000_0000.
